// File: rtl/pif_led_decoder.sv
// Receive-side decoder for the PIF red/green LED flasher: synchronises both lines,
// measures colour segments and flags steady colours. Optional filter: PIF_LED_GLITCH_FILTER_EN.
module pif_led_decoder #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000,
    parameter int GLITCH_LEN = 4
) (
    input  logic             xclk,
    input  logic             sys_rst,
    input  logic             red,
    input  logic             green,
    output logic             seg_valid,
    output logic [1:0]       seg_col,
    output logic [CNT_W-1:0] seg_len,
    output logic             seg_sat,
    output logic             steady,
    output logic [1:0]       steady_col,
    output logic [15:0]      seg_count
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_MAX - CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        MEASURE   = 2'd1,
        STEADY    = 2'd2
    } state_t;

    logic             r_red_s1;
    logic             r_red_s2;
    logic             r_grn_s1;
    logic             r_grn_s2;
    logic [1:0]       w_sync_col;
    logic [1:0]       w_s_col;
    logic [1:0]       r_prev_col;
    logic             w_chg;
    logic             w_emit;
    logic [CNT_W-1:0] r_run_cnt;
    logic             r_sat_flag;
    logic             r_origin;
    state_t           r_state;

    logic             r_seg_valid;
    logic [1:0]       r_seg_col;
    logic [CNT_W-1:0] r_seg_len;
    logic             r_seg_sat;
    logic             r_steady;
    logic [1:0]       r_steady_col;
    logic [15:0]      r_seg_count;

    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            r_red_s1 <= 1'b0;
            r_red_s2 <= 1'b0;
            r_grn_s1 <= 1'b0;
            r_grn_s2 <= 1'b0;
        end else begin
            r_red_s1 <= red;
            r_red_s2 <= r_red_s1;
            r_grn_s1 <= green;
            r_grn_s2 <= r_grn_s1;
        end
    end

    assign w_sync_col = {r_red_s2, r_grn_s2};

`ifdef PIF_LED_GLITCH_FILTER_EN
    localparam int              GC_W    = $clog2(GLITCH_LEN + 1);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'(GLITCH_LEN - 1);

    logic [1:0]      r_filt_col;
    logic [1:0]      r_cand_col;
    logic [GC_W-1:0] r_cand_cnt;

    // A new colour must be seen GLITCH_LEN samples in a row; any interruption restarts the count.
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            r_filt_col <= 2'b00;
            r_cand_col <= 2'b00;
            r_cand_cnt <= '0;
        end else if (w_sync_col == r_filt_col) begin
            r_cand_cnt <= '0;
        end else if ((w_sync_col == r_cand_col) && (r_cand_cnt != '0)) begin
            if (r_cand_cnt == GC_LAST) begin
                r_filt_col <= w_sync_col;
                r_cand_cnt <= '0;
            end else begin
                r_cand_cnt <= r_cand_cnt + GC_W'(1);
            end
        end else begin
            r_cand_col <= w_sync_col;
            r_cand_cnt <= GC_W'(1);
        end
    end

    assign w_s_col = r_filt_col;
`else
    logic w_unused_glitch;
    assign w_unused_glitch = (GLITCH_LEN > 1);
    assign w_s_col         = w_sync_col;
`endif

    assign w_chg  = (w_s_col != r_prev_col);
    // Segments that started in SYNC_WAIT have no trustworthy start, so they are never reported.
    assign w_emit = w_chg && ((r_state == MEASURE) || ((r_state == STEADY) && r_origin));

    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            r_state      <= SYNC_WAIT;
            r_prev_col   <= 2'b00;
            r_run_cnt    <= '0;
            r_sat_flag   <= 1'b0;
            r_origin     <= 1'b0;
            r_seg_valid  <= 1'b0;
            r_seg_col    <= 2'b00;
            r_seg_len    <= '0;
            r_seg_sat    <= 1'b0;
            r_steady     <= 1'b0;
            r_steady_col <= 2'b00;
            r_seg_count  <= 16'd0;
        end else begin
            r_prev_col  <= w_s_col;
            r_seg_valid <= w_emit;

            if (w_chg) begin
                r_run_cnt  <= CNT_W'(1);
                r_sat_flag <= 1'b0;
            end else if (r_run_cnt != CNT_MAX) begin
                r_run_cnt <= r_run_cnt + CNT_W'(1);
                if (r_run_cnt == CNT_PRE) begin
                    r_sat_flag <= 1'b1;
                end
            end

            if (w_emit) begin
                r_seg_col   <= r_prev_col;
                r_seg_len   <= r_run_cnt;
                r_seg_sat   <= r_sat_flag;
                r_seg_count <= r_seg_count + 16'd1;
            end

            case (r_state)
                SYNC_WAIT, MEASURE: begin
                    if (w_chg) begin
                        r_state <= MEASURE;
                    end else if (r_run_cnt == TIMEOUT_C) begin
                        r_state      <= STEADY;
                        r_origin     <= (r_state == MEASURE);
                        r_steady     <= 1'b1;
                        r_steady_col <= r_prev_col;
                    end
                end
                STEADY: begin
                    if (w_chg) begin
                        r_state      <= MEASURE;
                        r_steady     <= 1'b0;
                        r_steady_col <= 2'b00;
                    end
                end
                default: r_state <= SYNC_WAIT;
            endcase
        end
    end

    assign seg_valid  = r_seg_valid;
    assign seg_col    = r_seg_col;
    assign seg_len    = r_seg_len;
    assign seg_sat    = r_seg_sat;
    assign steady     = r_steady;
    assign steady_col = r_steady_col;
    assign seg_count  = r_seg_count;

endmodule

// File: doc/pif_led_decoder.md
Name: pif_led_decoder

Overview:
- Observer for the red/green outputs of the PIF LED flasher; this is the receive end of the LED interface.
- Synchronises both LED lines into its own clock domain and detects colour transitions.
- Reports every completed colour segment with its duration in clocks, and flags steady (non-flashing) states.
- Used on-chip for self-test and loopback of the flasher, and as a reusable bench checker.

Parameters:
- CNT_W, 16, width of the segment-length counter (min 4).
- TIMEOUT, 1000, cycles a colour must be held to declare steady (1 ≤ TIMEOUT ≤ 2^CNT_W-1).
- GLITCH_LEN, 4, stable-sample count needed to accept a new colour (used only with the filter, ≥2).

Ports:
- xclk  input  1  decoder clock; all logic on the rising edge.
- sys_rst  input  1  synchronous reset, active-high.
- red  input  1  LED red line, asynchronous to xclk.
- green  input  1  LED green line, asynchronous to xclk.
- seg_valid  output  1  one-cycle pulse: a segment completed.
- seg_col  output  2  colour of the completed segment, {red,green}: 00 off, 10 red, 01 green, 11 amber.
- seg_len  output  CNT_W  length of the completed segment in xclk cycles.
- seg_sat  output  1  seg_len saturated; true length is ≥ 2^CNT_W-1.
- steady  output  1  current colour held ≥ TIMEOUT cycles.
- steady_col  output  2  colour while steady=1, else 00.
- seg_count  output  16  completed segments since reset; wraps at 0xFFFF→0.

Behaviour:
- Reset (sys_rst=1 at an edge) drives to 0: all outputs, both synchroniser stages, prev_col, run_cnt. FSM enters SYNC_WAIT. Reset mid-segment discards all measurement state.
- Synchroniser: two flops per line. s_col = {red_s2, green_s2}.
- Change detect: chg = (s_col != prev_col). prev_col <= s_col every cycle.
- Latency: a level stable before edge E0 reaches red_s2/green_s2 at E1. The resulting seg_valid is registered at E2 and is high for exactly the cycle after E2.
- Run counter:
  - On chg, run_cnt <= 1.
  - Otherwise run_cnt <= run_cnt+1, saturating at 2^CNT_W-1.
  - sat_flag latches when the saturation value is reached and clears on chg.
- FSM states SYNC_WAIT, MEASURE, STEADY:
  - SYNC_WAIT: the first segment after reset has unknown start, so it is discarded.
    - chg → MEASURE, no seg_valid.
    - run_cnt==TIMEOUT → STEADY, with origin=0.
  - MEASURE: on chg, emit a segment → MEASURE.
    - run_cnt==TIMEOUT with no chg → STEADY, with origin=1.
  - STEADY: steady=1, steady_col=prev_col.
    - On chg: steady<=0 and steady_col<=00 on the same edge.
    - If origin=1, emit a segment. If origin=0, emit nothing.
    - Go to MEASURE.
- Emit a segment: on one edge, seg_valid<=1, seg_col<=old prev_col, seg_len<=run_cnt, seg_sat<=sat_flag, seg_count<=seg_count+1.
  - seg_col, seg_len and seg_sat hold their value until the next emit.
- chg and run_cnt==TIMEOUT on the same cycle: chg wins; no steady entry.
- Back-to-back changes on consecutive cycles produce consecutive seg_valid pulses with seg_len=1 each.
- Amber (11) and off (00) are ordinary colours. A two-line change (10→01) is a single transition.

Optional Feature:
- Macro: PIF_LED_GLITCH_FILTER_EN.
- Defined: a filter stage sits between the synchroniser and change detect.
  - A candidate colour is accepted into s_col only after GLITCH_LEN consecutive identical samples.
  - Shorter pulses are ignored entirely; run_cnt keeps counting through them.
  - Latency grows by GLITCH_LEN cycles.
  - Segment lengths are measured between accepted transitions, so steady-rate lengths are unchanged.
- Undefined: s_col comes directly from the synchroniser. The GLITCH_LEN parameter is ignored.

Test Plan:
- Reset check: sys_rst high 3 cycles, lines toggling → all outputs 0 and seg_count=0. Release with red=green=0 → no seg_valid.
- Basic decode: after reset drive red=1 (first change, discarded), hold 50 cycles, then green 30 cycles, then off → seg_valid twice, {10,50} then {01,30}; seg_count=2.
- Steady: green held 1200 cycles (TIMEOUT=1000) → steady=1, steady_col=01 from run_cnt==1000 onward. Then off → steady=0 and seg {01,1200,sat=0}.
- Saturation: CNT_W=8, TIMEOUT=200, red held 300 cycles then off → seg_len=255, seg_sat=1; the next normal segment has seg_sat=0.
- Glitch: 1-cycle red pulse between long off periods.
  - Without the macro → seg {00,n} then seg {10,1}.
  - With PIF_LED_GLITCH_FILTER_EN, GLITCH_LEN=4 → no seg_valid, seg_count unchanged.
- Reset mid-segment: assert sys_rst 20 cycles into a red segment → outputs clear, FSM SYNC_WAIT. The next change emits nothing; the following change emits a correct length.
